// File: rtl/cpu_bus_initiator.sv
// cpu_bus_initiator: local-bus master that runs MC68040-style single and
// line transfers on behalf of an internal requester. Line transfers that the
// responder burst-inhibits on the first beat are completed as three further
// single longword cycles at the wrapped line addresses.
module cpu_bus_initiator #(
   parameter logic [7:0] TIMEOUT_SLOTS = 8'd255,
   parameter logic [1:0] TT_CODE       = 2'b00
) (
   input  logic         CLK80,
   input  logic         RESET,
   input  logic         CLK40,
   // requester side
   input  logic         REQ,
   input  logic [31:0]  REQ_ADDR,
   input  logic         REQ_RW,
   input  logic [1:0]   REQ_SIZ,
   input  logic [127:0] REQ_WDATA,
   output logic         READY,
   output logic         DONE,
   output logic         ERR,
   output logic         TIMEOUT,
   output logic         CI,
   output logic [127:0] RDATA,
   // bus side
   output logic         TSn,
   output logic         TIPn,
   output logic [31:0]  A,
   output logic         RWn,
   output logic [1:0]   SIZ,
   output logic [1:0]   TT,
   output logic         BUS_OE,
   input  logic [31:0]  D_IN,
   output logic [31:0]  D_OUT,
   output logic         D_OE,
   input  logic         TACKn,
   input  logic         TBIn,
   input  logic         TCIn,
   input  logic         TEAn
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_REISSUE,
      S_FINISH
   } state_t;

   state_t         r_state;
   logic           r_ready;
   logic           r_done;
   logic           r_err;
   logic           r_timeout;
   logic           r_ci;
   logic           r_tsn;
   logic           r_tipn;
   logic [31:0]    r_a;
   logic           r_rwn;
   logic [1:0]     r_siz;
   logic [1:0]     r_tt;
   logic           r_bus_oe;
   logic [31:0]    r_dout;
   logic           r_d_oe;
   logic [1:0]     r_beat;
   logic [7:0]     r_tmo_cnt;
   logic [31:0]    r_addr;
   logic [127:0]   r_wdata;
   logic           r_line;
   logic           r_reissue;
   logic [31:0]    r_rbeat [4];

   logic [31:0]    w_wbeat [4];
   logic           w_tea;
   logic           w_tack;
   logic           w_tmo_hit;
   logic           w_last_beat;
   logic           w_go_finish;
   logic           w_go_reissue;
   logic           w_go_next_reissue;
   logic           w_advance;
   logic [1:0]     w_beat_next;
   logic [1:0]     w_wrap_idx;
   logic [31:0]    w_wrap_a;

   // split the latched write line and the read beat registers into lanes
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign w_wbeat[gi]           = r_wdata[gi*32 +: 32];
         assign RDATA[gi*32 +: 32]    = r_rbeat[gi];
      end
   endgenerate

   assign READY   = r_ready;
   assign DONE    = r_done;
   assign ERR     = r_err;
   assign TIMEOUT = r_timeout;
   assign CI      = r_ci;
   assign TSn     = r_tsn;
   assign TIPn    = r_tipn;
   assign A       = r_a;
   assign RWn     = r_rwn;
   assign SIZ     = r_siz;
   assign TT      = r_tt;
   assign BUS_OE  = r_bus_oe;
   assign D_OUT   = r_dout;
   assign D_OE    = r_d_oe;

   // decode the termination inputs seen in a WAIT slot into the next action
   always_comb begin
      w_tea             = ~TEAn;
      w_tack            = TEAn & ~TACKn;
      w_tmo_hit         = TEAn & TACKn & ((r_tmo_cnt + 8'd1) == TIMEOUT_SLOTS);
      w_last_beat       = (r_beat == 2'd3);
      w_beat_next       = r_beat + 2'd1;
      // burst-inhibit only matters on the first beat of a real line burst
      w_go_reissue      = w_tack & r_line & ~r_reissue & (r_beat == 2'd0) & ~TBIn;
      w_go_finish       = w_tea | w_tmo_hit | (w_tack & (~r_line | w_last_beat));
      w_go_next_reissue = w_tack & r_line & r_reissue & ~w_last_beat;
      w_advance         = w_tack & r_line & ~r_reissue & ~w_last_beat & ~w_go_reissue;
      // reissued beats walk the line with wrap inside the 16-byte block
      w_wrap_idx        = r_addr[3:2] + r_beat;
      w_wrap_a          = {r_addr[31:4], w_wrap_idx, r_addr[1:0]};
   end

   // bus-cycle state machine; everything except the DONE pulse moves only in slots
   always_ff @(posedge CLK80) begin
      if (RESET) begin
         r_state   <= S_IDLE;
         r_ready   <= 1'b1;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_timeout <= 1'b0;
         r_ci      <= 1'b0;
         r_tsn     <= 1'b1;
         r_tipn    <= 1'b1;
         r_a       <= '0;
         r_rwn     <= 1'b1;
         r_siz     <= 2'b00;
         r_tt      <= TT_CODE;
         r_bus_oe  <= 1'b0;
         r_dout    <= '0;
         r_d_oe    <= 1'b0;
         r_beat    <= '0;
         r_tmo_cnt <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_line    <= 1'b0;
         r_reissue <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_rbeat[i] <= '0;
         end
      end else begin
         // DONE lasts a single CLK80 edge; the following edge is never a slot
         r_done <= 1'b0;
         if (CLK40) begin
            case (r_state)
               S_IDLE: begin
                  if (REQ) begin
                     r_addr    <= REQ_ADDR;
                     r_wdata   <= REQ_WDATA;
                     r_line    <= (REQ_SIZ == 2'b11);
                     r_reissue <= 1'b0;
                     r_ready   <= 1'b0;
                     r_err     <= 1'b0;
                     r_timeout <= 1'b0;
                     r_ci      <= 1'b0;
                     r_beat    <= '0;
                     r_tmo_cnt <= '0;
                     for (int i = 0; i < 4; i++) begin
                        r_rbeat[i] <= '0;
                     end
                     r_tsn     <= 1'b0;
                     r_tipn    <= 1'b0;
                     r_bus_oe  <= 1'b1;
                     r_a       <= REQ_ADDR;
                     r_rwn     <= REQ_RW;
                     r_siz     <= REQ_SIZ;
                     r_tt      <= TT_CODE;
                     r_d_oe    <= ~REQ_RW;
                     r_dout    <= REQ_WDATA[31:0];
                     r_state   <= S_START;
                  end
               end

               S_START: begin
                  // terminations seen while TSn is low are not sampled here
                  r_tsn     <= 1'b1;
                  r_tmo_cnt <= '0;
                  r_state   <= S_WAIT;
               end

               S_WAIT: begin
                  if (w_tack) begin
                     r_tmo_cnt <= '0;
                     if (r_rwn) begin
                        r_rbeat[r_beat] <= D_IN;
                     end
                     if (!TCIn) begin
                        r_ci <= 1'b1;
                     end
                  end else if (!w_tea) begin
                     r_tmo_cnt <= r_tmo_cnt + 8'd1;
                  end

                  if (w_go_finish) begin
                     r_state   <= S_FINISH;
                     r_done    <= 1'b1;
                     r_err     <= w_tea | w_tmo_hit;
                     r_timeout <= w_tmo_hit;
                     r_tipn    <= 1'b1;
                     r_bus_oe  <= 1'b0;
                     r_d_oe    <= 1'b0;
                  end else if (w_go_reissue || w_go_next_reissue) begin
                     // one quiet slot before the next single longword cycle
                     r_state   <= S_REISSUE;
                     r_tipn    <= 1'b1;
                     r_beat    <= w_beat_next;
                     r_reissue <= 1'b1;
                  end else if (w_advance) begin
                     r_beat    <= w_beat_next;
                     r_dout    <= w_wbeat[w_beat_next];
                  end
               end

               S_REISSUE: begin
                  r_tsn   <= 1'b0;
                  r_tipn  <= 1'b0;
                  r_a     <= w_wrap_a;
                  r_siz   <= 2'b00;
                  r_dout  <= w_wbeat[r_beat];
                  r_state <= S_START;
               end

               S_FINISH: begin
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end

               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
